// File: rtl/div_seq_16by8_pkg.sv
// rtl/div_seq_16by8_pkg.sv - shared FSM encodings and defaults for the sequential divider
package div_seq_16by8_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DIV_DEFAULT_SIZE = 8;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int size = 8
) (
    input  logic [size:0]   p,
    input  logic            msb,
    input  logic [size-1:0] b,
    output logic [size:0]   p_next,
    output logic            q_bit
);

    // Widened by one bit so the shifted remainder never loses its carry before the compare.
    logic [size+1:0] t;

    always_comb begin
        t      = {p, msb};
        q_bit  = (t >= {2'b00, b});
        p_next = (size+1)'(q_bit ? (t - {2'b00, b}) : t);
    end

endmodule

// File: rtl/div_seq_16by8.sv
// rtl/div_seq_16by8.sv - sequential radix-2 restoring divider, 2*size by size bits
module div_seq_16by8
    import div_seq_16by8_pkg::*;
#(
    parameter int size = DIV_DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_en_in,
    input  logic [2*size-1:0] div_a,
    input  logic [size-1:0]   div_b,
    output logic              div_busy,
    output logic              div_en_out,
    output logic [2*size-1:0] div_q,
    output logic [size-1:0]   div_r,
    output logic              div_zero
);

    localparam int              CNT_W    = $clog2(2*size);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*size-1);

    div_state_t        state;
    logic [2*size-1:0] a_reg;
    logic [size-1:0]   b_reg;
    logic [size:0]     p;
    logic [CNT_W-1:0]  cnt;
    logic              zero_pend;

    logic [size:0]     p_next;
    logic              q_bit;

    div_step #(.size(size)) u_step (
        .p      (p),
        .msb    (a_reg[2*size-1]),
        .b      (b_reg),
        .p_next (p_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DIV_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            p          <= '0;
            cnt        <= '0;
            zero_pend  <= 1'b0;
            div_busy   <= 1'b0;
            div_en_out <= 1'b0;
            div_q      <= '0;
            div_r      <= '0;
            div_zero   <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    // The cycle after a result pulse retires it; only then is a new start accepted.
                    if (div_en_out) begin
                        div_en_out <= 1'b0;
                        div_busy   <= 1'b0;
                    end else if (div_en_in) begin
                        div_busy <= 1'b1;
                        if (div_b == '0) begin
                            zero_pend <= 1'b1;
                            state     <= DIV_DONE;
                        end else begin
                            zero_pend <= 1'b0;
                            a_reg     <= div_a;
                            b_reg     <= div_b;
                            p         <= '0;
                            cnt       <= '0;
                            state     <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    // a_reg shifts out dividend bits at the top and collects quotient bits at the bottom.
                    a_reg <= {a_reg[2*size-2:0], q_bit};
                    p     <= p_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= DIV_DONE;
                end
                DIV_DONE: begin
                    div_en_out <= 1'b1;
                    if (zero_pend) begin
                        div_q    <= '1;
                        div_r    <= '0;
                        div_zero <= 1'b1;
                    end else begin
                        div_q    <= a_reg;
                        div_r    <= p[size-1:0];
                        div_zero <= 1'b0;
                    end
                    state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_16by8.sv
// tb/tb_div_seq_16by8.sv - directed self-checking bench for div_seq_16by8
module tb_div_seq_16by8;

    logic        clk;
    logic        rst_n;
    logic        div_en_in;
    logic [15:0] div_a;
    logic [7:0]  div_b;
    logic        div_busy;
    logic        div_en_out;
    logic [15:0] div_q;
    logic [7:0]  div_r;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    div_seq_16by8 #(.size(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_en_in  (div_en_in),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_busy   (div_busy),
        .div_en_out (div_en_out),
        .div_q      (div_q),
        .div_r      (div_r),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Leaves the caller 1 time unit after the accepting edge E0.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b, input bit hold);
        @(negedge clk);
        div_a     = a;
        div_b     = b;
        div_en_in = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) div_en_in = 1'b0;
    endtask

    // Number of edges until div_en_out is seen high; -1 if it never arrives.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (div_en_out) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        div_en_in = 1'b0;
        div_a     = '0;
        div_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (div_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", div_busy); end
        checks++; if (div_en_out !== 1'b0) begin errors++; $display("FAIL reset_en_out got %b want 0", div_en_out); end
        checks++; if (div_q !== 16'h0)     begin errors++; $display("FAIL reset_q got %h want 0000", div_q); end
        checks++; if (div_r !== 8'h0)      begin errors++; $display("FAIL reset_r got %h want 00", div_r); end
        checks++; if (div_zero !== 1'b0)   begin errors++; $display("FAIL reset_zero got %b want 0", div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_1000_7();
        int e;
        start_op(16'd1000, 8'd7, 1'b0);
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL d1000_busy_e0 got %b want 1", div_busy); end
        wait_done(e);
        checks++; if (e !== 17)          begin errors++; $display("FAIL d1000_latency got %0d want 17", e); end
        checks++; if (div_q !== 16'd142) begin errors++; $display("FAIL d1000_q got %0d want 142", div_q); end
        checks++; if (div_r !== 8'd6)    begin errors++; $display("FAIL d1000_r got %0d want 6", div_r); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL d1000_zero got %b want 0", div_zero); end
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL d1000_busy_e17 got %b want 1", div_busy); end
        @(posedge clk);
        #1;
        checks++; if (div_en_out !== 1'b0) begin errors++; $display("FAIL d1000_pulse_width got %b want 0", div_en_out); end
        checks++; if (div_busy !== 1'b0)   begin errors++; $display("FAIL d1000_busy_e18 got %b want 0", div_busy); end
    endtask

    task automatic test_extremes();
        logic [15:0] va [3] = '{16'hFFFF, 16'hFFFF, 16'd5};
        logic [7:0]  vb [3] = '{8'hFF,    8'h01,    8'd10};
        logic [15:0] eq [3] = '{16'h0101, 16'hFFFF, 16'd0};
        logic [7:0]  er [3] = '{8'h00,    8'h00,    8'd5};
        int e;
        for (int k = 0; k < 3; k++) begin
            start_op(va[k], vb[k], 1'b0);
            wait_done(e);
            checks++; if (e !== 17)         begin errors++; $display("FAIL ext%0d_latency got %0d want 17", k, e); end
            checks++; if (div_q !== eq[k])  begin errors++; $display("FAIL ext%0d_q got %h want %h", k, div_q, eq[k]); end
            checks++; if (div_r !== er[k])  begin errors++; $display("FAIL ext%0d_r got %h want %h", k, div_r, er[k]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div_zero();
        int e;
        start_op(16'h1234, 8'd0, 1'b0);
        wait_done(e);
        checks++; if (e !== 1)            begin errors++; $display("FAIL dz_latency got %0d want 1", e); end
        checks++; if (div_q !== 16'hFFFF) begin errors++; $display("FAIL dz_q got %h want ffff", div_q); end
        checks++; if (div_r !== 8'h00)    begin errors++; $display("FAIL dz_r got %h want 00", div_r); end
        checks++; if (div_zero !== 1'b1)  begin errors++; $display("FAIL dz_flag got %b want 1", div_zero); end
        @(posedge clk);
        #1;
        checks++; if (div_busy !== 1'b0)  begin errors++; $display("FAIL dz_busy_clear got %b want 0", div_busy); end
        start_op(16'd20, 8'd4, 1'b0);
        wait_done(e);
        checks++; if (div_q !== 16'd5)    begin errors++; $display("FAIL dz_next_q got %0d want 5", div_q); end
        checks++; if (div_r !== 8'd0)     begin errors++; $display("FAIL dz_next_r got %0d want 0", div_r); end
        checks++; if (div_zero !== 1'b0)  begin errors++; $display("FAIL dz_next_flag got %b want 0", div_zero); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_start();
        int e;
        start_op(16'd100, 8'd3, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        div_a = 16'd50;
        div_b = 8'd5;
        wait_done(e);
        checks++; if (e + 4 !== 17)      begin errors++; $display("FAIL busy_latency got %0d want 17", e + 4); end
        checks++; if (div_q !== 16'd33)  begin errors++; $display("FAIL busy_q got %0d want 33", div_q); end
        checks++; if (div_r !== 8'd1)    begin errors++; $display("FAIL busy_r got %0d want 1", div_r); end
        @(posedge clk);
        #1;
        checks++; if (div_en_out !== 1'b0) begin errors++; $display("FAIL busy_single_pulse got %b want 0", div_en_out); end
        checks++; if (div_busy !== 1'b0)   begin errors++; $display("FAIL busy_e18 got %b want 0", div_busy); end
        @(posedge clk);
        #1;
        checks++; if (div_busy !== 1'b1)   begin errors++; $display("FAIL busy_accept_e19 got %b want 1", div_busy); end
        div_en_in = 1'b0;
        wait_done(e);
        checks++; if (e !== 17)          begin errors++; $display("FAIL b2b_latency got %0d want 17", e); end
        checks++; if (div_q !== 16'd10)  begin errors++; $display("FAIL b2b_q got %0d want 10", div_q); end
        checks++; if (div_r !== 8'd0)    begin errors++; $display("FAIL b2b_r got %0d want 0", div_r); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        int e;
        bit saw_pulse;
        start_op(16'd1000, 8'd7, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (div_busy !== 1'b0)   begin errors++; $display("FAIL rst_mid_busy got %b want 0", div_busy); end
        checks++; if (div_q !== 16'h0)     begin errors++; $display("FAIL rst_mid_q got %h want 0000", div_q); end
        checks++; if (div_r !== 8'h0)      begin errors++; $display("FAIL rst_mid_r got %h want 00", div_r); end
        saw_pulse = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (div_en_out) saw_pulse = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (div_en_out) saw_pulse = 1'b1;
        end
        checks++; if (saw_pulse !== 1'b0)  begin errors++; $display("FAIL rst_mid_no_pulse got %b want 0", saw_pulse); end
        start_op(16'd200, 8'd9, 1'b0);
        wait_done(e);
        checks++; if (e !== 17)          begin errors++; $display("FAIL rst_after_latency got %0d want 17", e); end
        checks++; if (div_q !== 16'd22)  begin errors++; $display("FAIL rst_after_q got %0d want 22", div_q); end
        checks++; if (div_r !== 8'd2)    begin errors++; $display("FAIL rst_after_r got %0d want 2", div_r); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_1000_7();
        test_extremes();
        test_div_zero();
        test_busy_start();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
